// File: rtl/noise_pkg.sv
// noise_pkg
// Shared definitions for the noise scheduler and the per-channel AWGN adders.
// Q8.7 noise samples, Q1.7 unsigned std, plus a saturating narrow helper used
// wherever an 18-bit sum has to land in a 16-bit noise word.
package noise_pkg;

  localparam int NOISE_QFRAC = 7;
  localparam int NOISE_W     = 16;
  localparam int STD_W       = 8;
  // sample (16b signed) x {0,std} (9b) -> 25b product; >>> 7 leaves 18b
  localparam int PROD_W      = NOISE_W + STD_W + 1;
  localparam int SUM_W       = PROD_W - NOISE_QFRAC;

  typedef struct packed {
    logic signed [NOISE_W-1:0] sample;
    logic        [STD_W-1:0]   std;
    logic signed [NOISE_W-1:0] mean;
  } noise_stage_t;

  // Clamp an 18-bit signed value into the 16-bit signed range.
  function automatic logic signed [NOISE_W-1:0] sat_noise(input logic signed [SUM_W-1:0] v);
    logic [SUM_W-NOISE_W:0] top;
    top = v[SUM_W-1:NOISE_W-1];
    if (top == '0 || top == '1)
      return v[NOISE_W-1:0];
    else if (v[SUM_W-1])
      return {1'b1, {(NOISE_W-1){1'b0}}};
    else
      return {1'b0, {(NOISE_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/awgn_noise_scheduler_rr_arbiter.sv
// rr_arbiter
// Masked priority-encoder round-robin arbiter. The winner is the lowest set
// request above last_q, otherwise the lowest set request overall. last_q only
// moves when en_i is high and someone requests.
// Ports: clk, rst (sync, active-high), en_i (commit the grant), req_i,
// gnt_o (one-hot, combinational), idx_o (winner index), any_o (req_i != 0).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  hi_req;
  logic          hi_any;

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < N; i++)
      hi_req[i] = req_i[i] && (i > int'(last_q));
    hi_any = |hi_req;
    any_o  = |req_i;

    // descending scan so the lowest matching index wins
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi_any ? hi_req[i] : req_i[i]) idx_o = IW'(i);
    end

    gnt_o  = any_o ? (N'(1) << idx_o) : '0;
    last_d = (en_i && any_o) ? idx_o : last_q;
  end

  // reset to N-1 so requester 0 has first priority
  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/random_gaussian_normal.sv
// random_gaussian_normal
// Approximate normal generator: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
// advanced every cycle; the four signed nibbles of the state are summed
// (central-limit approximation) and scaled by 16 into Q8.7.
// Ports: clk, rst (sync, active-high, reloads SEED), sample_o (signed Q8.7,
// combinational from the current state, new value every cycle).
module random_gaussian_normal #(
  parameter logic [15:0] SEED = 16'b101
) (
  input  logic               clk,
  input  logic               rst,
  output logic signed [15:0] sample_o
);

  logic [15:0] state_q, state_d;
  logic signed [5:0] acc;

  always_comb begin
    state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++)
      acc = acc + 6'($signed(state_q[i*4 +: 4]));
    sample_o = 16'(acc) <<< 4;
  end

  // an all-zero seed would lock the LFSR
  always_ff @(posedge clk) begin
    if (rst) state_q <= (SEED == '0) ? 16'h0001 : SEED;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/awgn_noise_scheduler.sv
// awgn_noise_scheduler
// Shares one Gaussian source among NUM_REQ channels. A round-robin grant
// latches the current sample plus the winner's std/mean into stage 1; stage 2
// computes ((sample * std) >>> 7) + mean and registers it with the winner id.
// Optional macro AWGN_NOISE_SAT_EN: saturate the final sum to 16 bits instead
// of wrapping.
// Ports: clk, rst (sync, active-high), enable_i, req_i / grant_o,
// cfg_we_i / cfg_addr_i / cfg_std_i / cfg_mean_i (per-channel config write),
// noise_valid_o / noise_o / noise_id_o (one pulse per grant, no backpressure).
module awgn_noise_scheduler
  import noise_pkg::*;
#(
  parameter  int                        NUM_REQ      = 4,
  parameter  logic [15:0]               SEED         = 16'b101,
  parameter  logic [STD_W-1:0]          DEFAULT_STD  = 8'd128,
  parameter  logic signed [NOISE_W-1:0] DEFAULT_MEAN = 16'sd0,
  localparam int                        IDW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        req_i,
  output logic [NUM_REQ-1:0]        grant_o,
  input  logic                      cfg_we_i,
  input  logic [IDW-1:0]            cfg_addr_i,
  input  logic [STD_W-1:0]          cfg_std_i,
  input  logic [NOISE_W-1:0]        cfg_mean_i,
  output logic                      noise_valid_o,
  output logic signed [NOISE_W-1:0] noise_o,
  output logic [IDW-1:0]            noise_id_o
);

  logic signed [NOISE_W-1:0] gen_sample;
  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IDW-1:0]            arb_idx;
  logic                      arb_any;
  logic                      take;

  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic                      s1_valid_q, s1_valid_d;
  noise_stage_t              s1_q, s1_d;
  logic [IDW-1:0]            s1_id_q, s1_id_d;
  logic [STD_W-1:0]          std_q  [NUM_REQ];
  logic [STD_W-1:0]          std_d  [NUM_REQ];
  logic signed [NOISE_W-1:0] mean_q [NUM_REQ];
  logic signed [NOISE_W-1:0] mean_d [NUM_REQ];
  logic                      noise_valid_q, noise_valid_d;
  logic signed [NOISE_W-1:0] noise_q, noise_d;
  logic [IDW-1:0]            noise_id_q, noise_id_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  prod_shr;
  logic signed [SUM_W-1:0]   scaled;
  logic signed [SUM_W-1:0]   sum;
  logic signed [NOISE_W-1:0] noise_next;

  random_gaussian_normal #(.SEED(SEED)) u_gen (
    .clk      (clk),
    .rst      (rst),
    .sample_o (gen_sample)
  );

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (enable_i),
    .req_i (req_i),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign take = enable_i && arb_any;

  // Stage-2 arithmetic on the latched stage-1 operands
  always_comb begin
    prod     = PROD_W'($signed(s1_q.sample)) * PROD_W'($signed({1'b0, s1_q.std}));
    prod_shr = prod >>> NOISE_QFRAC;
    scaled   = SUM_W'(prod_shr);
    sum      = scaled + SUM_W'($signed(s1_q.mean));
`ifdef AWGN_NOISE_SAT_EN
    noise_next = sat_noise(sum);
`else
    noise_next = NOISE_W'(sum);
`endif
  end

  always_comb begin
    std_d         = std_q;
    mean_d        = mean_q;
    grant_d       = take ? arb_gnt : '0;
    s1_valid_d    = take;
    s1_d          = s1_q;
    s1_id_d       = s1_id_q;
    noise_valid_d = s1_valid_q;
    noise_d       = noise_q;
    noise_id_d    = noise_id_q;

    // reads of std_q/mean_q below see the pre-write value on a colliding edge
    if (cfg_we_i && (int'(cfg_addr_i) < NUM_REQ)) begin
      std_d[cfg_addr_i]  = cfg_std_i;
      mean_d[cfg_addr_i] = $signed(cfg_mean_i);
    end

    if (take) begin
      s1_d.sample = gen_sample;
      s1_d.std    = std_q[arb_idx];
      s1_d.mean   = mean_q[arb_idx];
      s1_id_d     = arb_idx;
    end

    if (s1_valid_q) begin
      noise_d    = noise_next;
      noise_id_d = s1_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      s1_id_q       <= '0;
      noise_valid_q <= 1'b0;
      noise_q       <= '0;
      noise_id_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        std_q[i]  <= DEFAULT_STD;
        mean_q[i] <= DEFAULT_MEAN;
      end
    end else begin
      grant_q       <= grant_d;
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      s1_id_q       <= s1_id_d;
      noise_valid_q <= noise_valid_d;
      noise_q       <= noise_d;
      noise_id_q    <= noise_id_d;
      std_q         <= std_d;
      mean_q        <= mean_d;
    end
  end

  assign grant_o       = grant_q;
  assign noise_valid_o = noise_valid_q;
  assign noise_o       = noise_q;
  assign noise_id_o    = noise_id_q;

endmodule

// File: tb/tb_awgn_noise_scheduler.sv
// tb_awgn_noise_scheduler
// Directed bench for awgn_noise_scheduler (NUM_REQ=4). Inputs change on the
// falling edge, outputs are checked on the falling edge. A small reference
// model of the LFSR generator keeps the sample presented at each edge.
module tb_awgn_noise_scheduler;

  localparam int          N    = 4;
  localparam logic [15:0] SEED = 16'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [3:0]  req_i;
  logic [3:0]  grant_o;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [7:0]  cfg_std_i;
  logic [15:0] cfg_mean_i;
  logic        noise_valid_o;
  logic [15:0] noise_o;
  logic [1:0]  noise_id_o;

  int errors = 0;
  int checks = 0;

  awgn_noise_scheduler #(
    .NUM_REQ      (N),
    .SEED         (SEED),
    .DEFAULT_STD  (8'd128),
    .DEFAULT_MEAN (16'sd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .req_i         (req_i),
    .grant_o       (grant_o),
    .cfg_we_i      (cfg_we_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_std_i     (cfg_std_i),
    .cfg_mean_i    (cfg_mean_i),
    .noise_valid_o (noise_valid_o),
    .noise_o       (noise_o),
    .noise_id_o    (noise_id_o)
  );

  always #5 clk = ~clk;

  // Reference generator: hist1 = sample seen at the latest edge, hist2 = one before.
  logic [15:0]        gst;
  logic signed [15:0] hist1, hist2;

  function automatic logic [15:0] ref_sample(input logic [15:0] st);
    int s;
    logic [3:0] nib;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      nib = st[i*4 +: 4];
      s += nib[3] ? (int'(nib) - 16) : int'(nib);
    end
    return 16'(s * 16);
  endfunction

  always @(posedge clk) begin
    hist2 <= hist1;
    hist1 <= ref_sample(gst);
    gst   <= rst ? SEED : {gst[14:0], gst[15] ^ gst[13] ^ gst[12] ^ gst[10]};
  end

  function automatic logic [15:0] exp_noise(input int s, input int sd, input int mean);
    int r;
    r = ((s * sd) >>> 7) + mean;
`ifdef AWGN_NOISE_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    req_i    = '0;
    enable_i = 1'b1;
    cfg_we_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] sd, input logic [15:0] m);
    cfg_we_i   = 1'b1;
    cfg_addr_i = a;
    cfg_std_i  = sd;
    cfg_mean_i = m;
    cyc();
    cfg_we_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
    checks++; if (noise_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", noise_valid_o); end
    checks++; if (noise_o !== 16'h0000) begin errors++; $display("FAIL reset_noise: got %h want 0000", noise_o); end
    checks++; if (noise_id_o !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", noise_id_o); end
    req_i = 4'b1111;
    cyc();
    req_i = 4'b0000;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant_o); end
    cyc();
    checks++; if (noise_valid_o !== 1'b1 || noise_id_o !== 2'd0) begin
      errors++; $display("FAIL reset_first_out: got valid %b id %0d want valid 1 id 0", noise_valid_o, noise_id_o); end
  endtask

  // Also covers unity scaling: std=128, mean=0 gives the raw sample.
  task automatic test_round_robin();
    logic [3:0]  eg;
    logic [15:0] en;
    apply_reset();
    req_i = 4'b1111;
    for (int i = 0; i <= 8; i++) begin
      cyc();
      eg = (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000;
      checks++; if (grant_o !== eg) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant_o, eg); end
      if (i >= 1) begin
        en = exp_noise(int'(hist2), 128, 0);
        checks++; if (noise_valid_o !== 1'b1 || noise_id_o !== 2'((i - 1) % 4)) begin
          errors++; $display("FAIL rr_out[%0d]: got valid %b id %0d want valid 1 id %0d", i, noise_valid_o, noise_id_o, (i - 1) % 4); end
        checks++; if (noise_o !== en) begin errors++; $display("FAIL rr_unity[%0d]: got %h want %h", i, noise_o, en); end
      end
      if (i == 7) req_i = 4'b0000;
    end
    cyc();
    checks++; if (noise_valid_o !== 1'b0) begin errors++; $display("FAIL rr_drain: got valid %b want 0", noise_valid_o); end
  endtask

  task automatic test_scaling();
    logic [15:0] en;
    apply_reset();
    cfg_write(2'd2, 8'd64, 16'h0100);
    req_i = 4'b0100;
    cyc();
    req_i = 4'b0000;
    checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL scale_grant: got %b want 0100", grant_o); end
    cyc();
    en = 16'((int'(hist2) >>> 1) + 256);
    checks++; if (noise_valid_o !== 1'b1 || noise_id_o !== 2'd2 || noise_o !== en) begin
      errors++; $display("FAIL scale_half: got v%b id%0d %h want v1 id2 %h", noise_valid_o, noise_id_o, noise_o, en); end
    req_i = 4'b1000;
    cyc();
    req_i = 4'b0000;
    cyc();
    en = 16'(hist2);
    checks++; if (noise_id_o !== 2'd3 || noise_o !== en) begin
      errors++; $display("FAIL scale_other_ch: got id%0d %h want id3 %h", noise_id_o, noise_o, en); end
  endtask

  task automatic test_config_collision();
    logic [15:0] en;
    apply_reset();
    cfg_write(2'd1, 8'd128, 16'h0050);
    req_i      = 4'b0010;
    cfg_we_i   = 1'b1;
    cfg_addr_i = 2'd1;
    cfg_std_i  = 8'd0;
    cfg_mean_i = 16'h0050;
    cyc();
    req_i    = 4'b0000;
    cfg_we_i = 1'b0;
    checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL coll_grant: got %b want 0010", grant_o); end
    cyc();
    en = exp_noise(int'(hist2), 128, 16'h0050);
    checks++; if (noise_valid_o !== 1'b1 || noise_o !== en) begin
      errors++; $display("FAIL coll_old_std: got v%b %h want v1 %h", noise_valid_o, noise_o, en); end
    req_i = 4'b0010;
    cyc();
    req_i = 4'b0000;
    cyc();
    checks++; if (noise_valid_o !== 1'b1 || noise_o !== 16'h0050) begin
      errors++; $display("FAIL coll_new_std: got v%b %h want v1 0050", noise_valid_o, noise_o); end
  endtask

  task automatic test_saturation();
    logic [15:0] en;
`ifdef AWGN_NOISE_SAT_EN
    en = 16'h7FFF;
`else
    en = 16'hFE80;
`endif
    apply_reset();
    cfg_write(2'd0, 8'd255, 16'h7F00);
    force dut.gen_sample = 16'sh4000;
    req_i = 4'b0001;
    cyc();
    release dut.gen_sample;
    req_i = 4'b0000;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL sat_grant: got %b want 0001", grant_o); end
    cyc();
    checks++; if (noise_valid_o !== 1'b1 || noise_o !== en) begin
      errors++; $display("FAIL sat_value: got v%b %h want v1 %h", noise_valid_o, noise_o, en); end
  endtask

  task automatic test_enable();
    apply_reset();
    req_i = 4'b1111;
    cyc();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL en_first: got %b want 0001", grant_o); end
    enable_i = 1'b0;
    cyc();
    checks++; if (grant_o !== 4'b0000 || noise_valid_o !== 1'b1 || noise_id_o !== 2'd0) begin
      errors++; $display("FAIL en_drain: got g%b v%b id%0d want g0000 v1 id0", grant_o, noise_valid_o, noise_id_o); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (grant_o !== 4'b0000 || noise_valid_o !== 1'b0) begin
        errors++; $display("FAIL en_idle[%0d]: got g%b v%b want g0000 v0", i, grant_o, noise_valid_o); end
    end
    enable_i = 1'b1;
    cyc();
    req_i = 4'b0000;
    checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL en_resume: got %b want 0010", grant_o); end
    cyc();
  endtask

  task automatic test_reset_midflight();
    logic [15:0] en;
    apply_reset();
    cfg_write(2'd1, 8'd0, 16'h0000);
    req_i = 4'b0001;
    cyc();
    req_i = 4'b0000;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b want 0001", grant_o); end
    rst = 1'b1;
    cyc();
    checks++; if (noise_valid_o !== 1'b0 || grant_o !== 4'b0000) begin
      errors++; $display("FAIL mid_flush: got v%b g%b want v0 g0000", noise_valid_o, grant_o); end
    rst = 1'b0;
    cyc();
    checks++; if (noise_valid_o !== 1'b0) begin errors++; $display("FAIL mid_after: got v%b want 0", noise_valid_o); end
    req_i = 4'b0010;
    cyc();
    req_i = 4'b0000;
    cyc();
    en = 16'(hist2);
    checks++; if (noise_valid_o !== 1'b1 || noise_id_o !== 2'd1 || noise_o !== en) begin
      errors++; $display("FAIL mid_cfg_restored: got v%b id%0d %h want v1 id1 %h", noise_valid_o, noise_id_o, noise_o, en); end
  endtask

  initial begin
    rst        = 1'b1;
    enable_i   = 1'b1;
    req_i      = '0;
    cfg_we_i   = 1'b0;
    cfg_addr_i = '0;
    cfg_std_i  = '0;
    cfg_mean_i = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_scaling();
    test_config_collision();
    test_saturation();
    test_enable();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
